// File: rtl/board_pkg.sv
// Shared codes, index bounds, token layout and FSM encoding for the board scanner.
// No ports; imported by the interface, the counter and the scanner top.
package board_pkg;

   localparam int unsigned IDX_W  = 4;
   localparam int unsigned CELL_W = 2;

   localparam logic [IDX_W-1:0] IDX_MIN = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(9);

   // Cell contents as stored in ram_board; code 3 is reserved and passed through.
   typedef enum logic [CELL_W-1:0] {
      CELL_EMPTY = 2'b00,
      CELL_P1    = 2'b01,
      CELL_P2    = 2'b10,
      CELL_RSVD  = 2'b11
   } cell_code_t;

   // Macro-board outcome as reported by ram_board.state.
   typedef enum logic [CELL_W-1:0] {
      MST_OPEN   = 2'b00,
      MST_P1_WON = 2'b01,
      MST_P2_WON = 2'b10,
      MST_TIE    = 2'b11
   } macro_state_t;

   localparam logic KIND_CELL  = 1'b0;
   localparam logic KIND_STATE = 1'b1;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_ADDR       = 3'd1;
   localparam logic [2:0] ST_LATCH      = 3'd2;
   localparam logic [2:0] ST_EMIT_CELL  = 3'd3;
   localparam logic [2:0] ST_EMIT_STATE = 3'd4;
   localparam logic [2:0] ST_DONE       = 3'd5;

   // One output token as held in the scanner's output register.
   typedef struct packed {
      logic              kind;
      logic [IDX_W-1:0]  macro;
      logic [IDX_W-1:0]  micro;
      logic [CELL_W-1:0] value;
   } token_t;

endpackage

// File: rtl/board_scanner_if.sv
// Token stream between the scanner and its display / serial consumers.
// master: out_valid, out_kind, out_macro, out_micro, out_value driven; out_ready sampled.
// slave : mirror image.
interface board_scanner_if;
   import board_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic              out_kind;
   logic [IDX_W-1:0]  out_macro;
   logic [IDX_W-1:0]  out_micro;
   logic [CELL_W-1:0] out_value;

   modport master (
      output out_valid, out_kind, out_macro, out_micro, out_value,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_kind, out_macro, out_micro, out_value,
      output out_ready
   );

endinterface

// File: rtl/idx9_counter.sv
// Board index counter over 1..9.
// clock/reset_n : clock, synchronous active-low reset (value -> 0)
// clr           : force value to 0 (idle address)
// load          : force value to 1
// inc           : advance, wrapping 9 -> 1
// value         : current index (registered)
// at_max        : value == 9 (registered alongside value)
module idx9_counter
   import board_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic             inc,
   output logic [IDX_W-1:0] value,
   output logic             at_max
);

   logic [IDX_W-1:0] value_nxt;

   // Priority: clear, load, increment.
   always_comb begin
      value_nxt = value;
      if (clr) begin
         value_nxt = '0;
      end else if (load) begin
         value_nxt = IDX_MIN;
      end else if (inc) begin
         value_nxt = at_max ? IDX_MIN : value + IDX_W'(1);
      end
   end

   // at_max is registered from the next value so the flag never lags the count.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         value  <= '0;
         at_max <= 1'b0;
      end else begin
         value  <= value_nxt;
         at_max <= (value_nxt == IDX_MAX);
      end
   end

endmodule

// File: rtl/board_scanner.sv
// Walks all 81 cells of the ultimate tic-tac-toe board through ram_board's read
// port and streams one token per cell plus a macro-state token after each macro.
// clock, reset_n          : clock, synchronous active-low reset
// start                   : scan request, honoured only in idle
// ram_q, ram_state        : read data from ram_board (1-cycle latency)
// addr_macro, addr_micro  : read address, 1..9 while scanning, 0 otherwise
// tok (master)            : valid/ready token stream
// busy                    : scan in progress
// done                    : one-cycle pulse after the final token is accepted
module board_scanner
   import board_pkg::*;
(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [CELL_W-1:0]   ram_q,
   input  logic [CELL_W-1:0]   ram_state,
   output logic [IDX_W-1:0]    addr_macro,
   output logic [IDX_W-1:0]    addr_micro,
   board_scanner_if.master     tok,
   output logic                busy,
   output logic                done
);

   logic [2:0]        state_q, state_nxt;
   token_t            tok_q, tok_nxt;
   logic              valid_q, valid_nxt;
   logic              busy_q, busy_nxt;
   logic              done_q, done_nxt;
   logic [CELL_W-1:0] hold_q, hold_nxt;

   logic macro_clr, macro_load, macro_inc, macro_at_max;
   logic micro_clr, micro_load, micro_inc, micro_at_max;
   logic [IDX_W-1:0] macro_idx, micro_idx;

   // Index counters double as the registered read address.
   idx9_counter u_macro (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (macro_clr),
      .load    (macro_load),
      .inc     (macro_inc),
      .value   (macro_idx),
      .at_max  (macro_at_max)
   );

   idx9_counter u_micro (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (micro_clr),
      .load    (micro_load),
      .inc     (micro_inc),
      .value   (micro_idx),
      .at_max  (micro_at_max)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_nxt  = state_q;
      tok_nxt    = tok_q;
      valid_nxt  = valid_q;
      busy_nxt   = busy_q;
      done_nxt   = 1'b0;
      hold_nxt   = hold_q;
      macro_clr  = 1'b0;
      macro_load = 1'b0;
      macro_inc  = 1'b0;
      micro_clr  = 1'b0;
      micro_load = 1'b0;
      micro_inc  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               macro_load = 1'b1;
               micro_load = 1'b1;
               busy_nxt   = 1'b1;
               state_nxt  = ST_ADDR;
            end
         end

         // Address already on the port; ram_board samples it this edge.
         ST_ADDR: begin
            state_nxt = ST_LATCH;
         end

         ST_LATCH: begin
            tok_nxt.kind  = KIND_CELL;
            tok_nxt.macro = macro_idx;
            tok_nxt.micro = micro_idx;
            tok_nxt.value = ram_q;
            // Macro state is read alongside the ninth cell and replayed after it.
            if (micro_at_max) begin
               hold_nxt = ram_state;
            end
            valid_nxt = 1'b1;
            state_nxt = ST_EMIT_CELL;
         end

         ST_EMIT_CELL: begin
            if (tok.out_ready) begin
               if (!micro_at_max) begin
                  micro_inc = 1'b1;
                  valid_nxt = 1'b0;
                  state_nxt = ST_ADDR;
               end else begin
                  tok_nxt.kind  = KIND_STATE;
                  tok_nxt.micro = '0;
                  tok_nxt.value = hold_q;
                  state_nxt     = ST_EMIT_STATE;
               end
            end
         end

         ST_EMIT_STATE: begin
            if (tok.out_ready) begin
               valid_nxt = 1'b0;
               if (!macro_at_max) begin
                  macro_inc  = 1'b1;
                  micro_load = 1'b1;
                  state_nxt  = ST_ADDR;
               end else begin
                  macro_clr = 1'b1;
                  micro_clr = 1'b1;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         tok_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_nxt;
         tok_q   <= tok_nxt;
         valid_q <= valid_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
         hold_q  <= hold_nxt;
      end
   end

   assign addr_macro    = macro_idx;
   assign addr_micro    = micro_idx;
   assign busy          = busy_q;
   assign done          = done_q;
   assign tok.out_valid = valid_q;
   assign tok.out_kind  = tok_q.kind;
   assign tok.out_macro = tok_q.macro;
   assign tok.out_micro = tok_q.micro;
   assign tok.out_value = tok_q.value;

endmodule

// File: tb/tb_board_scanner.sv
// Self-checking bench for board_scanner: ram_board read model, token-order
// reference built from the board contents, per-cycle stream monitor.
module tb_board_scanner;
   import board_pkg::*;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       start;
   logic [1:0] ram_q;
   logic [1:0] ram_state;
   logic [3:0] addr_macro;
   logic [3:0] addr_micro;
   logic       busy;
   logic       done;

   board_scanner_if tok_if ();

   board_scanner dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .ram_q      (ram_q),
      .ram_state  (ram_state),
      .addr_macro (addr_macro),
      .addr_micro (addr_micro),
      .tok        (tok_if),
      .busy       (busy),
      .done       (done)
   );

   always #5 clock = ~clock;

   // ram_board read side: registered read, one clock of latency.
   logic [1:0] cell_mem [16][16];
   logic [1:0] st_mem   [16];

   always @(posedge clock) begin
      ram_q     <= cell_mem[addr_macro][addr_micro];
      ram_state <= st_mem[addr_macro];
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] pack_tok(input logic k, input logic [3:0] m,
                                            input logic [3:0] u, input logic [1:0] v);
      return {k, m, u, v};
   endfunction

   // Reference: every cell of a macro in order, then that macro's state.
   logic [10:0] exp_q [$];

   task automatic build_expect();
      exp_q.delete();
      for (int m = 1; m <= 9; m++) begin
         for (int u = 1; u <= 9; u++)
            exp_q.push_back(pack_tok(1'b0, 4'(m), 4'(u), cell_mem[m][u]));
         exp_q.push_back(pack_tok(1'b1, 4'(m), 4'd0, st_mem[m]));
      end
   endtask

   task automatic clear_board();
      for (int m = 0; m < 16; m++) begin
         st_mem[m] = 2'b00;
         for (int u = 0; u < 16; u++) cell_mem[m][u] = 2'b00;
      end
   endtask

   // Stream monitor: address range, stall stability, token order, done pulses.
   bit          mon_en = 1'b0;
   bit          stall_prev = 1'b0;
   logic [10:0] prev_tok;
   logic [10:0] cur_tok;
   logic [10:0] seen [128];
   int          tok_cnt = 0;
   int          done_cnt = 0;
   bit          addr_ok;

   always @(negedge clock) begin
      cur_tok = pack_tok(tok_if.out_kind, tok_if.out_macro, tok_if.out_micro, tok_if.out_value);
      if (!reset_n || !mon_en) begin
         stall_prev = 1'b0;
      end else begin
         if (busy)
            addr_ok = (addr_macro >= 4'd1) && (addr_macro <= 4'd9) &&
                      (addr_micro >= 4'd1) && (addr_micro <= 4'd9);
         else
            addr_ok = (addr_macro == 4'd0) && (addr_micro == 4'd0);
         check("addr_range", 32'(addr_ok), 32'd1);
         if (stall_prev) begin
            check("stall_valid", 32'(tok_if.out_valid), 32'd1);
            check("stall_fields", 32'(cur_tok), 32'(prev_tok));
         end
         if (tok_if.out_valid && tok_if.out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_token: got %0h expected none", cur_tok);
            end else begin
               check("token", 32'(cur_tok), 32'(exp_q.pop_front()));
            end
            if (tok_cnt < 128) seen[tok_cnt] = cur_tok;
            tok_cnt++;
         end
         if (done) done_cnt++;
         stall_prev = tok_if.out_valid && !tok_if.out_ready;
         prev_tok   = cur_tok;
      end
   end

   // Consumer ready: tied high or pseudo-random, changed away from the clock edge.
   bit rand_ready = 1'b0;

   initial begin
      tok_if.out_ready = 1'b1;
      forever begin
         @(posedge clock);
         #2;
         tok_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(tok_if.out_valid), 32'd0);
      check({tag, "_kind"},  32'(tok_if.out_kind),  32'd0);
      check({tag, "_macro"}, 32'(tok_if.out_macro), 32'd0);
      check({tag, "_micro"}, 32'(tok_if.out_micro), 32'd0);
      check({tag, "_value"}, 32'(tok_if.out_value), 32'd0);
      check({tag, "_amac"},  32'(addr_macro),       32'd0);
      check({tag, "_amic"},  32'(addr_micro),       32'd0);
      check({tag, "_busy"},  32'(busy),             32'd0);
      check({tag, "_done"},  32'(done),             32'd0);
   endtask

   task automatic begin_scan();
      build_expect();
      tok_cnt  = 0;
      done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Returns edges since the start edge at which done was first seen, and the first valid.
   task automatic wait_done(output int n, output int first_valid);
      n = 0;
      first_valid = -1;
      while (!done && n < 3000) begin
         if (tok_if.out_valid && first_valid < 0) first_valid = n;
         tick();
         n++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
      end
   endtask

   task automatic wait_tokens(input int cnt);
      int guard = 0;
      while (tok_cnt < cnt && guard < 2000) begin
         tick();
         guard++;
      end
      check("wait_tokens", 32'(tok_cnt >= cnt), 32'd1);
   endtask

   task automatic post_checks(input string tag);
      check({tag, "_tok_cnt"},  32'(tok_cnt),      32'd90);
      check({tag, "_done_cnt"}, 32'(done_cnt),     32'd1);
      check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_done_low"}, 32'(done),         32'd0);
      check({tag, "_busy_low"}, 32'(busy),         32'd0);
   endtask

   initial begin
      int n;
      int fv;

      reset_n = 1'b0;
      start   = 1'b0;
      clear_board();
      repeat (3) tick();
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();
      mon_en = 1'b1;

      // Empty board, free-running consumer: latency and total scan length.
      begin_scan();
      check("busy_after_start", 32'(busy), 32'd1);
      check("addr_first", 32'({addr_macro, addr_micro}), 32'h11);
      wait_done(n, fv);
      check("first_valid_edge", 32'(fv), 32'd2);
      check("done_edge", 32'(n), 32'd252);
      tick();
      post_checks("empty");
      check("empty_tok0", 32'(seen[0]), 32'(pack_tok(1'b0, 4'd1, 4'd1, 2'b00)));
      check("empty_tok9", 32'(seen[9]), 32'(pack_tok(1'b1, 4'd1, 4'd0, 2'b00)));

      // P1 takes the top row of macro 2; start during DONE must be ignored.
      cell_mem[2][1] = CELL_P1;
      cell_mem[2][2] = CELL_P1;
      cell_mem[2][3] = CELL_P1;
      st_mem[2]      = MST_P1_WON;
      begin_scan();
      wait_done(n, fv);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_done", 32'(busy), 32'd0);
      tick();
      check("start_in_done2", 32'(busy), 32'd0);
      post_checks("p1row");
      check("p1_tok10", 32'(seen[10]), 32'(pack_tok(1'b0, 4'd2, 4'd1, 2'b01)));
      check("p1_tok12", 32'(seen[12]), 32'(pack_tok(1'b0, 4'd2, 4'd3, 2'b01)));
      check("p1_tok13", 32'(seen[13]), 32'(pack_tok(1'b0, 4'd2, 4'd4, 2'b00)));
      check("p1_tok19", 32'(seen[19]), 32'(pack_tok(1'b1, 4'd2, 4'd0, 2'b01)));
      check("p1_tok89", 32'(seen[89]), 32'(pack_tok(1'b1, 4'd9, 4'd0, 2'b00)));

      // Random board, random backpressure, stray start at token 40.
      for (int m = 1; m <= 9; m++) begin
         st_mem[m] = 2'($urandom_range(0, 3));
         for (int u = 1; u <= 9; u++) cell_mem[m][u] = 2'($urandom_range(0, 3));
      end
      rand_ready = 1'b1;
      begin_scan();
      wait_tokens(40);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy_ignored", 32'(busy), 32'd1);
      wait_done(n, fv);
      tick();
      repeat (5) tick();
      post_checks("rand");
      rand_ready = 1'b0;

      // Reset mid-scan at token 50, then a fresh scan from (1,1).
      clear_board();
      cell_mem[1][1] = CELL_P2;
      cell_mem[9][9] = CELL_RSVD;
      st_mem[9]      = MST_TIE;
      begin_scan();
      wait_tokens(50);
      reset_n = 1'b0;
      tick();
      check_all_zero("midreset");
      reset_n = 1'b1;
      exp_q.delete();
      tick();
      check("idle_after_reset", 32'(busy), 32'd0);
      begin_scan();
      wait_done(n, fv);
      check("restart_done_edge", 32'(n), 32'd252);
      tick();
      post_checks("restart");
      check("restart_tok0",  32'(seen[0]),  32'(pack_tok(1'b0, 4'd1, 4'd1, 2'b10)));
      check("restart_tok88", 32'(seen[88]), 32'(pack_tok(1'b0, 4'd9, 4'd9, 2'b11)));
      check("restart_tok89", 32'(seen[89]), 32'(pack_tok(1'b1, 4'd9, 4'd0, 2'b11)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
